// File: rtl/pll_rst_seq_pkg.sv
// Shared definitions for the PLL reset sequencer.
// - state_t : 2-bit FSM state encoding (PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3)
// - max3    : helper used to size the shared sequencer timer
package pll_rst_seq_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/pll_rst_seq_if.sv
// Signal bundle between the reset sequencer and its surroundings.
// - master : the environment side (PLL lock status, restart request in;
//            PLL reset, system reset, status and debug counters out)
// - slave  : the sequencer side
// Signals:
//   pll_locked    PLL locked, asynchronous to the sequencer clock
//   restart       1-cycle request to re-sequence from PLL reset
//   pll_rst       active-high PLL reset
//   sys_rst_n     active-low reset to PLL-clocked logic
//   ready         high while the sequencer is in RUN
//   timeout_pulse 1-cycle pulse per lock timeout
//   retry_cnt     saturating count of lock timeouts
//   loss_cnt      saturating count of losses of lock while in RUN
interface pll_rst_seq_if #(
  parameter int CNT_W = 8
);
  logic             pll_locked;
  logic             restart;
  logic             pll_rst;
  logic             sys_rst_n;
  logic             ready;
  logic             timeout_pulse;
  logic [CNT_W-1:0] retry_cnt;
  logic [CNT_W-1:0] loss_cnt;

  modport master (
    output pll_locked, restart,
    input  pll_rst, sys_rst_n, ready, timeout_pulse, retry_cnt, loss_cnt
  );

  modport slave (
    input  pll_locked, restart,
    output pll_rst, sys_rst_n, ready, timeout_pulse, retry_cnt, loss_cnt
  );
endinterface

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level signal.
// Ports:
//   clk   destination clock
//   rst_n synchronous active-low reset, all stages clear to 0
//   d     asynchronous input
//   q     synchronized output, STAGES cycles behind d
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // NOTE: sequential state is written with non-blocking assignments so every
  // stage samples the previous value of its neighbour on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_rst_seq.sv
// Reset sequencer downstream of the system PLL, clocked by the board refclk.
// Holds the PLL in reset, waits for lock, qualifies lock for a stable window,
// then releases the system reset. Lock timeouts and losses of lock in RUN put
// the PLL back into reset and are counted for debug.
// Ports:
//   clk   free-running reference clock (same net as the PLL refclk)
//   rst_n synchronous active-low reset
//   bus   slave side of pll_rst_seq_if (see the interface for signal list)
module pll_rst_seq
  import pll_rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 500000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int CNT_W          = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  pll_rst_seq_if.slave  bus
);

  localparam int unsigned TIMER_MAX =
    max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int TIMER_W = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;

  // Terminal timer values: the timer starts at 0 on state entry, so a state
  // lasting N cycles ends when the timer reads N-1.
  localparam logic [TIMER_W-1:0] RST_LAST     = TIMER_W'(PLL_RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(STABLE_CYCLES - 1);

  logic locked_s;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.pll_locked),
    .q     (locked_s)
  );

  state_t             state;
  logic [TIMER_W-1:0] timer;
  logic               pll_rst_q;
  logic               sys_rst_n_q;
  logic               ready_q;
  logic               timeout_q;
  logic [CNT_W-1:0]   retry_q;
  logic [CNT_W-1:0]   loss_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= PLL_RST;
      timer       <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      timeout_q   <= 1'b0;
      retry_q     <= '0;
      loss_q      <= '0;
    end else begin
      timeout_q <= 1'b0;

      case (state)
        PLL_RST: begin
          if (bus.restart) begin
            timer <= '0;
          end else if (timer == RST_LAST) begin
            state     <= WAIT_LOCK;
            timer     <= '0;
            pll_rst_q <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        WAIT_LOCK: begin
          if (bus.restart) begin
            state     <= PLL_RST;
            timer     <= '0;
            pll_rst_q <= 1'b1;
          end else if (locked_s) begin
            state <= STABLE;
            timer <= '0;
          end else if (timer == TIMEOUT_LAST) begin
            state     <= PLL_RST;
            timer     <= '0;
            pll_rst_q <= 1'b1;
            timeout_q <= 1'b1;
            if (retry_q != '1) retry_q <= retry_q + 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        STABLE: begin
          if (bus.restart) begin
            state     <= PLL_RST;
            timer     <= '0;
            pll_rst_q <= 1'b1;
          end else if (!locked_s) begin
            // A lock glitch before release only restarts qualification; the
            // PLL is not reset and nothing is counted.
            state <= WAIT_LOCK;
            timer <= '0;
          end else if (timer == STABLE_LAST) begin
            state       <= RUN;
            timer       <= '0;
            sys_rst_n_q <= 1'b1;
            ready_q     <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        RUN: begin
          // Loss of lock is checked first so a coincident restart still
          // counts the loss; both lead to the same single transition.
          if (!locked_s || bus.restart) begin
            state       <= PLL_RST;
            timer       <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            if (!locked_s && (loss_q != '1)) loss_q <= loss_q + 1'b1;
          end
        end

        default: begin
          state       <= PLL_RST;
          timer       <= '0;
          pll_rst_q   <= 1'b1;
          sys_rst_n_q <= 1'b0;
          ready_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pll_rst       = pll_rst_q;
  assign bus.sys_rst_n     = sys_rst_n_q;
  assign bus.ready         = ready_q;
  assign bus.timeout_pulse = timeout_q;
  assign bus.retry_cnt     = retry_q;
  assign bus.loss_cnt      = loss_q;

endmodule
